// File: rtl/fp_pkg.sv
// Shared widths and the aligned-operand bundle passed from alignment to add/normalize.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MAN_W  = 24;
    localparam int ALN_W  = 27;

    typedef struct packed {
        logic [EXP_W-1:0] exp_max;
        logic [ALN_W-1:0] sig_big;
        logic [ALN_W-1:0] sig_small;
        logic             sign_big;
        logic             eff_sub;
        logic             swap;
    } align_s;

endpackage

// File: rtl/fp_rshift_sticky.sv
// Right shifter for the aligned significand; every bit shifted out is folded into bit 0.
module fp_rshift_sticky
    import fp_pkg::*;
(
    input  logic [ALN_W-1:0] value,
    input  logic [EXP_W-1:0] shamt,
    output logic [ALN_W-1:0] result
);

    logic [ALN_W-1:0] shifted;
    logic [ALN_W-1:0] lost_mask;
    logic             sticky;

    always_comb begin
        shifted   = '0;
        lost_mask = '0;
        sticky    = 1'b0;
        result    = '0;
        if (shamt >= EXP_W'(ALN_W)) begin
            // everything falls off the end; only the sticky survives
            result = {{(ALN_W-1){1'b0}}, |value};
        end else begin
            shifted   = value >> shamt;
            lost_mask = ~({ALN_W{1'b1}} << shamt);
            sticky    = |(value & lost_mask);
            result    = {shifted[ALN_W-1:1], shifted[0] | sticky};
        end
    end

endmodule

// File: rtl/fp_align_stage.sv
// Two-stage operand alignment: S1 orders operands by magnitude, S2 shifts the smaller
// significand into place with guard/round/sticky. Elastic valid/ready between stages.
module fp_align_stage
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign1,
    input  logic              sign2,
    input  logic              op_sub,
    input  logic [EXP_W-1:0]  exp1_d,
    input  logic [EXP_W-1:0]  exp2_d,
    input  logic [FRAC_W-1:0] sig1_o,
    input  logic [FRAC_W-1:0] sig2_o,
    input  logic [1:0]        n_concat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  exp_max,
    output logic [ALN_W-1:0]  sig_big,
    output logic [ALN_W-1:0]  sig_small,
    output logic              sign_big,
    output logic              eff_sub,
    output logic              swap
);

    logic [MAN_W-1:0] man1, man2;
    logic             op1_big;
    logic [EXP_W-1:0] diff_c;

    logic             s1_valid;
    logic             s1_swap;
    logic [EXP_W-1:0] s1_diff;
    logic [EXP_W-1:0] s1_exp_max;
    logic [MAN_W-1:0] s1_big_man;
    logic [MAN_W-1:0] s1_small_man;
    logic             s1_sign_big;
    logic             s1_eff_sub;

    logic             s2_valid;
    align_s           s2_q;
    logic [ALN_W-1:0] small_aligned;

    logic             s1_adv, s2_adv;

    assign man1    = {~n_concat[1], sig1_o};
    assign man2    = {~n_concat[0], sig2_o};
    // ties on the full magnitude keep op1 as the big operand
    assign op1_big = (exp1_d > exp2_d) || ((exp1_d == exp2_d) && (man1 >= man2));
    assign diff_c  = op1_big ? (exp1_d - exp2_d) : (exp2_d - exp1_d);

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv && !reset;

    fp_rshift_sticky u_rshift (
        .value  ({s1_small_man, 3'b000}),
        .shamt  (s1_diff),
        .result (small_aligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s1_swap      <= 1'b0;
            s1_diff      <= '0;
            s1_exp_max   <= '0;
            s1_big_man   <= '0;
            s1_small_man <= '0;
            s1_sign_big  <= 1'b0;
            s1_eff_sub   <= 1'b0;
            s2_valid     <= 1'b0;
            s2_q         <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_swap      <= !op1_big;
                    s1_diff      <= diff_c;
                    s1_exp_max   <= op1_big ? exp1_d : exp2_d;
                    s1_big_man   <= op1_big ? man1 : man2;
                    s1_small_man <= op1_big ? man2 : man1;
                    s1_sign_big  <= op1_big ? sign1 : (sign2 ^ op_sub);
                    s1_eff_sub   <= sign1 ^ sign2 ^ op_sub;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_q.exp_max   <= s1_exp_max;
                    s2_q.sig_big   <= {s1_big_man, 3'b000};
                    s2_q.sig_small <= small_aligned;
                    s2_q.sign_big  <= s1_sign_big;
                    s2_q.eff_sub   <= s1_eff_sub;
                    s2_q.swap      <= s1_swap;
                end
            end
        end
    end

    assign out_valid = s2_valid;
    assign exp_max   = s2_q.exp_max;
    assign sig_big   = s2_q.sig_big;
    assign sig_small = s2_q.sig_small;
    assign sign_big  = s2_q.sign_big;
    assign eff_sub   = s2_q.eff_sub;
    assign swap      = s2_q.swap;

endmodule

// File: tb/tb_fp_align_stage.sv
// Bench for fp_align_stage: directed cases, backpressure, reset, then random traffic
// scored against an arithmetic alignment model.
module tb_fp_align_stage;
    import fp_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic              sign1, sign2, op_sub;
    logic [EXP_W-1:0]  exp1_d, exp2_d;
    logic [FRAC_W-1:0] sig1_o, sig2_o;
    logic [1:0]        n_concat;
    logic              out_valid;
    logic              out_ready;
    logic [EXP_W-1:0]  exp_max;
    logic [ALN_W-1:0]  sig_big, sig_small;
    logic              sign_big, eff_sub, swap;

    int n_vec  = 0;
    int n_miss = 0;
    int n_in   = 0;
    int n_out  = 0;
    align_s exp_q[$];

    always #5 clk = ~clk;

    fp_align_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign1     (sign1),
        .sign2     (sign2),
        .op_sub    (op_sub),
        .exp1_d    (exp1_d),
        .exp2_d    (exp2_d),
        .sig1_o    (sig1_o),
        .sig2_o    (sig2_o),
        .n_concat  (n_concat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp_max   (exp_max),
        .sig_big   (sig_big),
        .sig_small (sig_small),
        .sign_big  (sign_big),
        .eff_sub   (eff_sub),
        .swap      (swap)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Alignment computed as magnitude comparison plus integer division by 2**diff.
    function automatic align_s model(input logic s1, input logic s2, input logic op,
                                     input logic [7:0] e1, input logic [7:0] e2,
                                     input logic [22:0] f1, input logic [22:0] f2,
                                     input logic [1:0] nc);
        align_s r;
        longint m1, m2, k1, k2, mb, ms, ext, p, sm;
        int eb, es, d;
        bit op2_big;
        m1 = (nc[1] ? 0 : 64'd8388608) + longint'(f1);
        m2 = (nc[0] ? 0 : 64'd8388608) + longint'(f2);
        k1 = longint'(e1) * 64'd16777216 + m1;
        k2 = longint'(e2) * 64'd16777216 + m2;
        op2_big = (k2 > k1);
        eb = op2_big ? int'(e2) : int'(e1);
        es = op2_big ? int'(e1) : int'(e2);
        mb = op2_big ? m2 : m1;
        ms = op2_big ? m1 : m2;
        d  = eb - es;
        ext = ms * 8;
        if (d >= 27) begin
            sm = (ms != 0) ? 1 : 0;
        end else begin
            p  = 64'd1 << d;
            sm = ext / p;
            if ((ext % p) != 0) sm = sm | 1;
        end
        r.exp_max   = 8'(eb);
        r.sig_big   = 27'(mb * 8);
        r.sig_small = 27'(sm);
        r.swap      = op2_big;
        r.sign_big  = op2_big ? (s2 ^ op) : s1;
        r.eff_sub   = s1 ^ s2 ^ op;
        return r;
    endfunction

    task automatic sample();
        align_s e;
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("exp_max",   64'(exp_max),   64'(e.exp_max));
                check("sig_big",   64'(sig_big),   64'(e.sig_big));
                check("sig_small", 64'(sig_small), 64'(e.sig_small));
                check("sign_big",  64'(sign_big),  64'(e.sign_big));
                check("eff_sub",   64'(eff_sub),   64'(e.eff_sub));
                check("swap",      64'(swap),      64'(e.swap));
            end
        end
        if (in_valid && in_ready) begin
            n_in++;
            exp_q.push_back(model(sign1, sign2, op_sub, exp1_d, exp2_d, sig1_o, sig2_o, n_concat));
        end
    endtask

    task automatic step();
        #1;
        sample();
        @(negedge clk);
    endtask

    task automatic drive_rand();
        sign1    = 1'($urandom);
        sign2    = 1'($urandom);
        op_sub   = 1'($urandom);
        exp1_d   = 8'($urandom);
        case ($urandom % 4)
            0:       exp2_d = exp1_d;
            1:       exp2_d = 8'(int'(exp1_d) + int'($urandom_range(0, 34)) - 17);
            default: exp2_d = 8'($urandom);
        endcase
        sig1_o   = 23'($urandom);
        sig2_o   = 23'($urandom);
        n_concat = 2'($urandom);
    endtask

    task automatic directed(input string tag, input logic s1, input logic s2, input logic op,
                            input logic [7:0] e1, input logic [7:0] e2,
                            input logic [22:0] f1, input logic [22:0] f2, input logic [1:0] nc,
                            input logic [7:0] w_exp, input logic [26:0] w_big,
                            input logic [26:0] w_small, input logic w_swap);
        sign1 = s1; sign2 = s2; op_sub = op;
        exp1_d = e1; exp2_d = e2; sig1_o = f1; sig2_o = f2; n_concat = nc;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        check({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        check({tag, "_lat2"},  64'(out_valid), 64'd1);
        check({tag, "_exp"},   64'(exp_max),   64'(w_exp));
        check({tag, "_big"},   64'(sig_big),   64'(w_big));
        check({tag, "_small"}, 64'(sig_small), 64'(w_small));
        check({tag, "_swap"},  64'(swap),      64'(w_swap));
        sample();
        @(negedge clk);
    endtask

    initial begin
        int sent;
        int got_in_low;
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        sign1 = 0; sign2 = 0; op_sub = 0;
        exp1_d = '0; exp2_d = '0; sig1_o = '0; sig2_o = '0; n_concat = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_outs", 64'({exp_max, sig_big, sig_small, sign_big, eff_sub, swap}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        directed("one_plus_one", 0, 0, 0, 8'd127, 8'd127, 23'h0, 23'h0, 2'b00,
                 8'd127, 27'h4000000, 27'h4000000, 1'b0);
        directed("swap", 0, 0, 1, 8'd100, 8'd101, 23'h0, 23'h0, 2'b00,
                 8'd101, 27'h4000000, 27'h2000000, 1'b1);
        directed("sticky", 0, 0, 0, 8'd131, 8'd127, 23'h0, 23'h000001, 2'b00,
                 8'd131, 27'h4000000, 27'h0400001, 1'b0);
        directed("saturate", 0, 0, 0, 8'd127, 8'd100, 23'h0, 23'h000001, 2'b00,
                 8'd127, 27'h4000000, 27'h0000001, 1'b0);
        directed("subnormal", 0, 1, 0, 8'd1, 8'd1, 23'h4, 23'h2, 2'b11,
                 8'd1, 27'h20, 27'h10, 1'b0);

        // backpressure: six pairs, sink stalled for the first three cycles
        sent = 0;
        got_in_low = 0;
        n_out = 0;
        for (int cyc = 0; cyc < 40 && (sent < 6 || exp_q.size() != 0); cyc++) begin
            if (sent < 6) begin
                drive_rand();
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (cyc >= 3);
            #1;
            if (cyc == 2) check("bp_in_ready_low", 64'(in_ready), 64'd0);
            if (cyc == 2) check("bp_out_held", 64'(out_valid), 64'd1);
            if (in_valid && in_ready) sent++;
            sample();
            @(negedge clk);
        end
        check("bp_all_in",  64'(sent),  64'd6);
        check("bp_all_out", 64'(n_out), 64'd6);

        // reset with a full pipe
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_rand();
            in_valid = 1'b1;
            step();
        end
        #1;
        check("full_before_rst", 64'(out_valid), 64'd1);
        reset = 1'b1;
        drive_rand();
        #1;
        check("rst_in_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        check("rst_flush_out_valid", 64'(out_valid), 64'd0);
        check("rst_flush_in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        #1;
        check("rst_flush_no_ghost", 64'(out_valid), 64'd0);
        @(negedge clk);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            drive_rand();
            in_valid  = ($urandom % 10) < 7;
            out_ready = ($urandom % 10) < 7;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        #1;
        check("drain_out_valid", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
